// File: rtl/dn_residual_window.sv
// dn_residual_window: N-th order finite difference of modulo-ADC samples,
// folded residual res = M_lambda(D^N y) - D^N y, packed WIN per frame and
// handed to the Kn folding-integer stage with a valid/ready handshake.
module dn_residual_window #(
    parameter int W           = 16,
    parameter int N_ORDER     = 2,
    parameter int LAMBDA_LOG2 = 2,
    parameter int WIN         = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [W-1:0]           sample_in,
    output logic                   dn_valid,
    input  logic                   dn_ready,
    output logic [WIN-1:0][W-1:0]  dn_res,
    output logic [15:0]            frame_cnt
);

    localparam int WD      = W + N_ORDER;
    localparam int WR      = WD + 1;
    localparam int IW      = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int LIM_INT = 2**(W-1) - 2**(LAMBDA_LOG2+1);
    localparam logic signed [WR-1:0] LIM_POS = WR'(LIM_INT);
    localparam logic signed [WR-1:0] LIM_NEG = -LIM_POS;

    typedef enum logic [1:0] {PRIME, COLLECT, HOLD} state_t;

    state_t                 state;
    logic [2:0]             pcnt;
    logic [IW-1:0]          idx;
    logic signed [WD-1:0]   taps  [N_ORDER];
    logic signed [WD-1:0]   stage [N_ORDER];
    logic signed [WD-1:0]   dn;
    logic signed [WR-1:0]   fold;
    logic signed [WR-1:0]   res_full;
    logic [W-1:0]           res_sat;
    logic                   accept;

    assign accept = s_valid & s_ready;

    // Difference cascade: stage j carries D^j of the incoming sample, each
    // order subtracting the previous sample's value of the order below.
    always_comb begin
        logic signed [WD-1:0] acc;
        acc = {{N_ORDER{sample_in[W-1]}}, sample_in};
        for (int j = 0; j < N_ORDER; j++) begin
            stage[j] = acc;
            acc      = acc - taps[j];
        end
        dn = acc;
    end

    // Fold into [-lambda, lambda), form the residual, then clamp to a multiple
    // of 2*lambda so a saturated residual still lies on the fold grid.
    always_comb begin
        fold     = {{(WR-LAMBDA_LOG2-1){dn[LAMBDA_LOG2]}}, dn[LAMBDA_LOG2:0]};
        res_full = fold - {dn[WD-1], dn};
        if (res_full > LIM_POS)
            res_sat = LIM_POS[W-1:0];
        else if (res_full < LIM_NEG)
            res_sat = LIM_NEG[W-1:0];
        else
            res_sat = res_full[W-1:0];
    end

    // Frame sequencer: prime the taps, collect WIN residuals, hold until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PRIME;
            s_ready   <= 1'b0;
            dn_valid  <= 1'b0;
            dn_res    <= '0;
            frame_cnt <= 16'd0;
            pcnt      <= 3'd0;
            idx       <= '0;
            for (int j = 0; j < N_ORDER; j++) taps[j] <= '0;
        end else begin
            case (state)
                PRIME: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        for (int j = 0; j < N_ORDER; j++) taps[j] <= stage[j];
                        if (pcnt == 3'(N_ORDER-1)) begin
                            pcnt  <= 3'd0;
                            state <= COLLECT;
                        end else begin
                            pcnt <= pcnt + 3'd1;
                        end
                    end
                end
                COLLECT: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        for (int j = 0; j < N_ORDER; j++) taps[j] <= stage[j];
                        dn_res[idx] <= res_sat;
                        if (idx == IW'(WIN-1)) begin
                            state    <= HOLD;
                            dn_valid <= 1'b1;
                            s_ready  <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (dn_valid && dn_ready) begin
                        dn_valid  <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        idx       <= '0;
                        pcnt      <= 3'd0;
                        s_ready   <= 1'b1;
                        state     <= PRIME;
                        for (int j = 0; j < N_ORDER; j++) taps[j] <= '0;
                    end
                end
                default: begin
                    state   <= PRIME;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dn_residual_window.sv
// tb_dn_residual_window: scoreboard bench for dn_residual_window using the
// default parameters (W=16, N=2, lambda=4, WIN=13, 15 samples per frame).
module tb_dn_residual_window;

    localparam int W     = 16;
    localparam int N     = 2;
    localparam int WIN   = 13;
    localparam int FRAME = WIN + N;
    localparam int LAM   = 4;
    localparam int LIM   = 2**(W-1) - 2*LAM;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  s_valid;
    logic                  s_ready;
    logic [W-1:0]          sample_in;
    logic                  dn_valid;
    logic                  dn_ready;
    logic [WIN-1:0][W-1:0] dn_res;
    logic [15:0]           frame_cnt;

    int checks     = 0;
    int failures   = 0;
    int sb[$];
    int exp_frames = 0;
    int cnt        = 0;
    int h1         = 0;
    int h2         = 0;
    bit seen       = 0;
    logic [WIN-1:0][W-1:0] snap;

    int ramp  [FRAME] = '{0, 1, 2, 3, -4, -3, -2, -1, 0, 1, 2, 3, -4, -3, -2};
    int zeros [FRAME] = '{default: 0};
    int alt   [FRAME];

    dn_residual_window #(.W(W), .N_ORDER(N), .LAMBDA_LOG2(2), .WIN(WIN)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .sample_in (sample_in),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_res    (dn_res),
        .frame_cnt (frame_cnt)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference fold using modular arithmetic instead of bit slicing
    function automatic int modelResidual(input int d);
        int m;
        int r;
        m = (((d + LAM) % (2*LAM)) + 2*LAM) % (2*LAM) - LAM;
        r = m - d;
        if (r > LIM)  r = LIM;
        if (r < -LIM) r = -LIM;
        return r;
    endfunction

    task automatic modelAccept(input int y);
        if (cnt >= N) sb.push_back(modelResidual(y - 2*h1 + h2));
        h2 = h1;
        h1 = y;
        cnt++;
        if (cnt == FRAME) begin
            cnt = 0;
            h1  = 0;
            h2  = 0;
        end
    endtask

    task automatic modelReset();
        cnt = 0;
        h1  = 0;
        h2  = 0;
        sb.delete();
        exp_frames = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic applyStimulus(input int y);
        int n;
        n         = 0;
        sample_in = W'(y);
        s_valid   = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checkOutput("s_ready_timeout", int'(s_ready), 1);
            s_valid = 1'b0;
            return;
        end
        modelAccept(y);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic sendFrame(input int ys [FRAME], input bit gap);
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(ys[i]);
            if (i == FRAME-2) checkOutput("dn_valid_early", int'(dn_valid), 0);
            if (i == FRAME-1) checkOutput("dn_valid_latency", int'(dn_valid), 1);
            if (gap && i != FRAME-1) @(negedge clk);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_dn_valid", int'(dn_valid), 0);
        checkOutput("rst_s_ready", int'(s_ready), 0);
        checkOutput("rst_frame_cnt", int'(frame_cnt), 0);
        checkOutput("rst_dn_res_zero", int'(dn_res == '0), 1);
    endtask

    // Output monitor: pops the scoreboard when a frame appears, then watches it stay frozen
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            seen = 0;
        end else if (dn_valid) begin
            if (!seen) begin
                seen = 1;
                snap = dn_res;
                checkOutput("frame_cnt_at_valid", int'(frame_cnt), exp_frames);
                checkOutput("s_ready_in_hold", int'(s_ready), 0);
                for (int i = 0; i < WIN; i++) begin
                    if (sb.size() == 0) begin
                        checkOutput("sb_underflow", sb.size(), 1);
                    end else begin
                        checkOutput($sformatf("dn_res[%0d]", i), int'($signed(dn_res[i])), sb.pop_front());
                    end
                end
            end else begin
                checkOutput("dn_res_frozen", int'(dn_res == snap), 1);
                checkOutput("s_ready_in_hold", int'(s_ready), 0);
            end
            if (dn_ready) begin
                exp_frames = (exp_frames + 1) & 16'hFFFF;
                seen       = 0;
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        for (int i = 0; i < FRAME; i++) alt[i] = (i % 2 == 0) ? -4 : 3;
        reset     = 1'b1;
        s_valid   = 1'b0;
        dn_ready  = 1'b1;
        sample_in = '0;
        repeat (2) @(negedge clk);
        checkResetState();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("s_ready_after_reset", int'(s_ready), 1);

        $display("[TB] scenario 1: all-zero frame");
        sendFrame(zeros, 1'b0);
        @(negedge clk);
        checkOutput("frame_cnt_s1", int'(frame_cnt), 1);

        $display("[TB] scenario 2: wrapping ramp");
        sendFrame(ramp, 1'b0);
        @(negedge clk);
        checkOutput("frame_cnt_s2", int'(frame_cnt), exp_frames);

        $display("[TB] scenario 3: downstream stall");
        dn_ready = 1'b0;
        sendFrame(ramp, 1'b0);
        s_valid   = 1'b1;
        sample_in = W'(3);
        repeat (50) @(negedge clk);
        checkOutput("dn_valid_stalled", int'(dn_valid), 1);
        checkOutput("frame_cnt_stalled", int'(frame_cnt), 2);
        dn_ready = 1'b1;
        s_valid  = 1'b0;
        @(negedge clk);
        checkOutput("dn_valid_released", int'(dn_valid), 0);
        checkOutput("s_ready_released", int'(s_ready), 1);
        checkOutput("frame_cnt_s3", int'(frame_cnt), exp_frames);

        $display("[TB] scenario 4: reset mid-frame");
        for (int i = 0; i < 7; i++) applyStimulus(ramp[i]);
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        checkResetState();
        reset = 1'b0;
        checkOutput("s_ready_release_cycle", int'(s_ready), 0);
        @(negedge clk);
        checkOutput("s_ready_after_release", int'(s_ready), 1);
        sendFrame(ramp, 1'b0);
        @(negedge clk);
        checkOutput("frame_cnt_s4", int'(frame_cnt), 1);

        $display("[TB] scenario 5: sparse s_valid");
        sendFrame(ramp, 1'b1);

        $display("[TB] scenario 6: alternating -4/3");
        sendFrame(alt, 1'b0);
        sendFrame(alt, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("sb_leftover", sb.size(), 0);
        checkOutput("frame_cnt_final", int'(frame_cnt), exp_frames);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
